isolde_xif_issue_buffer: RTL
============================

# isolde_xif_issue_buffer

Coprocessor-side issue/commit stage attached to the `coproc_issue` and `coproc_commit` modports of `isolde_cv_x_if`. It accepts offloaded instructions and holds them in program order until the CPU commits or kills them. It releases only committed instructions, in order, to the coprocessor execution pipeline over a valid/ready handshake. An external combinational predecoder supplies the accept and writeback decisions.

## Interface
- `DEPTH`, 4: buffer entries; power of two, ≥2.
- `X_NUM_RS`, 2: must match the interface instance.
- `X_ID_WIDTH`, 4: must match the interface instance.
- `X_RFR_WIDTH`, 32: must match the interface instance.
- `clk_i`  in  1  clock; one clock domain; all state on the rising edge.
- `rst_i`  in  1  reset; **synchronous, active-high**.
- `xif_issue`  modport  `coproc_issue`  issue request/response.
- `xif_commit`  modport  `coproc_commit`  commit/kill stream.
- `predec_instr_o`  out  32  equals `issue_req.instr`, driven to the predecoder.
- `predec_accept_i`  in  1  instruction belongs to this coprocessor.
- `predec_writeback_i`  in  1  instruction writes `rd`.
- `exec_valid_o`  out  1  head entry is committed and presented.
- `exec_ready_i`  in  1  execution stage takes the head.
- `exec_instr_o`  out  32  head instruction.
- `exec_id_o`  out  X_ID_WIDTH  head id.
- `exec_rs_o`  out  X_NUM_RS×X_RFR_WIDTH  head source operands.
- `exec_writeback_o`  out  1  head writeback flag.
- `count_o`  out  $clog2(DEPTH)+1  occupied entries, including killed entries not yet drained.

## Operation
- **Entry fields:** `instr`, `id`, `rs`, `writeback`, `valid`, `committed`, `killed`. The buffer is a circular array with `wr_ptr` and `rd_ptr` of width $clog2(DEPTH)+1; the extra bit is the wrap bit.
- **Full/empty:** `full` when the pointers differ only in the MSB. `empty` when the pointers are equal.
- **Issue ready:** `issue_ready = !full && &issue_req.rs_valid && !rst_i`. It is based on registered `full` only, so a pop in the same cycle does not free a slot for a push.
- **Issue response** (combinational, valid while `issue_valid`):
  - `accept = predec_accept_i`
  - `writeback = predec_accept_i & predec_writeback_i`
  - `dualwrite`, `dualread`, `loadstore`, `ecswrite`, `exc` are all 0.
- **Issue handshake** (`issue_valid && issue_ready`):
  - With `accept=1`: write the entry at `wr_ptr` with `committed=0` and `killed=0`, then increment `wr_ptr`.
  - With `accept=0`: nothing is stored.
- **Commit** (`commit_valid`): match the oldest entry with `valid && !committed && !killed && id==commit.id`.
  - `commit_kill=0` sets `committed`.
  - `commit_kill=1` sets `killed`.
  - No match means the instruction was rejected or is unknown: the commit is ignored with no error.
- **Same-cycle issue and commit, same id:** the commit applies to the entry allocated in that cycle if no older match exists.
- **Head drain:**
  - Head `killed`: pop automatically in one cycle; `exec_valid_o` stays 0.
  - Head `committed`: assert `exec_valid_o`, and pop on `exec_ready_i`.
  - Head uncommitted: stall.
- **Outputs:** all `exec_*` outputs are driven from the registered head entry, not from commit inputs.
- **Reset** (`rst_i` high at an edge):
  - Pointers and all `valid` bits clear.
  - `exec_valid_o=0`, `count_o=0`, `issue_ready=0`.
  - `exec_*` data outputs are 0 (entry data cleared).
  - A reset mid-operation discards all in-flight entries, including committed ones.

## Timing
- Issue at cycle N with commit in the same cycle N: `exec_valid_o` at N+1.
- Commit at cycle M>N: `exec_valid_o` at M+1.
- A killed head frees its slot one cycle after the kill is visible at the head.
- Push and pop in the same cycle are allowed when not full; `count_o` is unchanged.
- `exec_valid_o`, once asserted, holds with stable data until `exec_ready_i`.
- `issue_resp` is combinational from `predec_*`; there is no registered path from issue to response.

## Structure
- Package `isolde_xif_buf_pkg` holds:
  - the `xif_buf_entry_t` struct, parameterised via localparams that mirror the interface defaults;
  - the `PTR_W` function.
- One natural sub-module, `isolde_xif_id_match`: a combinational oldest-first priority search over entries, starting from `rd_ptr` with wrap. It returns a one-hot match vector and a hit flag.
- Target size: 200–300 lines of RTL.

## Test plan
- **Basic flow:** issue id=3 `instr=0x0000_200B` with accept=1, commit id=3 kill=0 in the same cycle, `exec_ready_i=1` → `exec_valid_o` at N+1 with `exec_id_o=3`; `count_o` is 1 then 0.
- **Kill at head:** issue ids 1, 2, 3; kill id 1; commit ids 2 and 3 → id 1 is never presented; ids 2 and 3 appear in order; `count_o` reaches 0.
- **Full and wrap:** DEPTH=4, issue 4 instructions without commits → `issue_ready=0`. Commit one, pop it, issue again → `wr_ptr` wraps; order is preserved across 12 instructions.
- **Reject and operand stall:**
  - accept=0 → `issue_resp.accept=0` and `count_o` is unchanged; a later commit for that id is ignored.
  - `rs_valid=2'b01` → `issue_ready=0` until `2'b11`.
- **Duplicate ids and backpressure:** two in-flight entries with id=5, one commit for id=5 → only the older entry is committed. With `exec_ready_i=0` for 5 cycles, `exec_*` outputs stay stable.
- **Reset mid-operation:** 3 entries with 1 committed, assert `rst_i` for one cycle → next cycle `count_o=0`, `exec_valid_o=0`; the subsequent issue/commit flow works normally.

Source files
------------

// File: rtl/isolde_xif_buf_pkg.sv
// Shared types and helpers for the X-interface issue buffer.
// Entry layout mirrors the default isolde_cv_x_if parameterisation.
package isolde_xif_buf_pkg;

  localparam int unsigned XifNumRs    = 2;
  localparam int unsigned XifIdWidth  = 4;
  localparam int unsigned XifRfrWidth = 32;

  typedef struct packed {
    logic [31:0]                     instr;
    logic [XifIdWidth-1:0]           id;
    logic [XifNumRs*XifRfrWidth-1:0] rs;
    logic                            writeback;
    logic                            valid;
    logic                            committed;
    logic                            killed;
  } xif_buf_entry_t;

  // Pointer width including the wrap bit.
  function automatic int unsigned PTR_W(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/isolde_cv_x_if.sv
// Minimal CV-X-IF subset: issue request/response and commit/kill stream.
interface isolde_cv_x_if #(
  parameter int unsigned X_NUM_RS    = 2,
  parameter int unsigned X_ID_WIDTH  = 4,
  parameter int unsigned X_RFR_WIDTH = 32
);

  logic                            issue_valid;
  logic                            issue_ready;
  logic [31:0]                     issue_req_instr;
  logic [X_ID_WIDTH-1:0]           issue_req_id;
  logic [X_NUM_RS*X_RFR_WIDTH-1:0] issue_req_rs;
  logic [X_NUM_RS-1:0]             issue_req_rs_valid;
  logic                            issue_resp_accept;
  logic                            issue_resp_writeback;
  logic                            issue_resp_dualwrite;
  logic                            issue_resp_dualread;
  logic                            issue_resp_loadstore;
  logic                            issue_resp_ecswrite;
  logic                            issue_resp_exc;

  logic                            commit_valid;
  logic [X_ID_WIDTH-1:0]           commit_id;
  logic                            commit_kill;

  modport coproc_issue (
    input  issue_valid, issue_req_instr, issue_req_id, issue_req_rs, issue_req_rs_valid,
    output issue_ready, issue_resp_accept, issue_resp_writeback, issue_resp_dualwrite,
           issue_resp_dualread, issue_resp_loadstore, issue_resp_ecswrite, issue_resp_exc
  );

  modport coproc_commit (
    input commit_valid, commit_id, commit_kill
  );

  modport cpu_issue (
    output issue_valid, issue_req_instr, issue_req_id, issue_req_rs, issue_req_rs_valid,
    input  issue_ready, issue_resp_accept, issue_resp_writeback, issue_resp_dualwrite,
           issue_resp_dualread, issue_resp_loadstore, issue_resp_ecswrite, issue_resp_exc
  );

  modport cpu_commit (
    output commit_valid, commit_id, commit_kill
  );

endinterface

// File: rtl/isolde_xif_id_match.sv
// Oldest-first id search over buffer entries, starting at the read index and wrapping.
module isolde_xif_id_match #(
  parameter int unsigned Depth   = 4,
  parameter int unsigned IdWidth = 4
) (
  input  logic [$clog2(Depth)-1:0] rd_idx_i,
  input  logic [Depth-1:0]         cand_i,
  input  logic [Depth*IdWidth-1:0] ids_i,
  input  logic [IdWidth-1:0]       id_i,
  output logic [Depth-1:0]         match_o,
  output logic                     hit_o
);

  localparam int unsigned AW = $clog2(Depth);

  logic [AW-1:0] idx;
  logic          hit;

  always_comb begin
    match_o = '0;
    hit     = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      idx = rd_idx_i + AW'(i);
      if (!hit && cand_i[idx] && (ids_i[idx*IdWidth +: IdWidth] == id_i)) begin
        match_o[idx] = 1'b1;
        hit          = 1'b1;
      end
    end
  end

  assign hit_o = hit;

endmodule

// File: rtl/isolde_xif_issue_buffer.sv
// Coprocessor issue/commit buffer: holds offloaded instructions in program order and
// releases only committed ones to the execution stage; killed heads drain silently.
module isolde_xif_issue_buffer
  import isolde_xif_buf_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  // Must keep the package defaults: entry storage uses xif_buf_entry_t.
  parameter int unsigned X_NUM_RS    = XifNumRs,
  parameter int unsigned X_ID_WIDTH  = XifIdWidth,
  parameter int unsigned X_RFR_WIDTH = XifRfrWidth
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  isolde_cv_x_if.coproc_issue             xif_issue,
  isolde_cv_x_if.coproc_commit            xif_commit,
  output logic [31:0]                     predec_instr_o,
  input  logic                            predec_accept_i,
  input  logic                            predec_writeback_i,
  output logic                            exec_valid_o,
  input  logic                            exec_ready_i,
  output logic [31:0]                     exec_instr_o,
  output logic [X_ID_WIDTH-1:0]           exec_id_o,
  output logic [X_NUM_RS*X_RFR_WIDTH-1:0] exec_rs_o,
  output logic                            exec_writeback_o,
  output logic [$clog2(DEPTH):0]          count_o
);

  localparam int unsigned PW = PTR_W(DEPTH);
  localparam int unsigned AW = PW - 1;

  xif_buf_entry_t entries_q [DEPTH];
  xif_buf_entry_t entries_d [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;

  logic [AW-1:0]             wr_idx, rd_idx;
  logic                      full, empty;
  logic                      push, pop;
  logic                      head_valid;
  xif_buf_entry_t            head;
  logic [DEPTH-1:0]          cand;
  logic [DEPTH*X_ID_WIDTH-1:0] ids;
  logic [DEPTH-1:0]          match;
  logic                      hit;

  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];
  assign full   = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty  = (wr_ptr_q == rd_ptr_q);

  // Issue response is purely combinational from the predecoder.
  assign predec_instr_o                 = xif_issue.issue_req_instr;
  assign xif_issue.issue_ready          = !full && (&xif_issue.issue_req_rs_valid) && !rst_i;
  assign xif_issue.issue_resp_accept    = predec_accept_i;
  assign xif_issue.issue_resp_writeback = predec_accept_i & predec_writeback_i;
  assign xif_issue.issue_resp_dualwrite = 1'b0;
  assign xif_issue.issue_resp_dualread  = 1'b0;
  assign xif_issue.issue_resp_loadstore = 1'b0;
  assign xif_issue.issue_resp_ecswrite  = 1'b0;
  assign xif_issue.issue_resp_exc       = 1'b0;

  assign push = xif_issue.issue_valid && xif_issue.issue_ready && predec_accept_i;

  assign head       = entries_q[rd_idx];
  assign head_valid = !empty && head.valid;
  assign pop        = head_valid && (head.killed || (head.committed && exec_ready_i));

  assign exec_valid_o     = head_valid && head.committed && !head.killed;
  assign exec_instr_o     = head.instr;
  assign exec_id_o        = head.id;
  assign exec_rs_o        = head.rs;
  assign exec_writeback_o = head.writeback;
  assign count_o          = wr_ptr_q - rd_ptr_q;

  always_comb begin
    cand = '0;
    ids  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cand[i] = entries_q[i].valid && !entries_q[i].committed && !entries_q[i].killed;
      ids[i*X_ID_WIDTH +: X_ID_WIDTH] = entries_q[i].id;
    end
  end

  isolde_xif_id_match #(
    .Depth   (DEPTH),
    .IdWidth (X_ID_WIDTH)
  ) u_id_match (
    .rd_idx_i (rd_idx),
    .cand_i   (cand),
    .ids_i    (ids),
    .id_i     (xif_commit.commit_id),
    .match_o  (match),
    .hit_o    (hit)
  );

  always_comb begin
    entries_d = entries_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;

    if (push) begin
      entries_d[wr_idx].instr     = xif_issue.issue_req_instr;
      entries_d[wr_idx].id        = xif_issue.issue_req_id;
      entries_d[wr_idx].rs        = xif_issue.issue_req_rs;
      entries_d[wr_idx].writeback = predec_accept_i & predec_writeback_i;
      entries_d[wr_idx].valid     = 1'b1;
      entries_d[wr_idx].committed = 1'b0;
      entries_d[wr_idx].killed    = 1'b0;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    // The entry allocated this cycle is the youngest, so it only catches a commit
    // when nothing already stored matches.
    if (xif_commit.commit_valid) begin
      if (hit) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (match[i]) begin
            if (xif_commit.commit_kill) entries_d[i].killed    = 1'b1;
            else                        entries_d[i].committed = 1'b1;
          end
        end
      end else if (push && (xif_commit.commit_id == xif_issue.issue_req_id)) begin
        if (xif_commit.commit_kill) entries_d[wr_idx].killed    = 1'b1;
        else                        entries_d[wr_idx].committed = 1'b1;
      end
    end

    if (pop) begin
      entries_d[rd_idx].valid = 1'b0;
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      entries_q <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      entries_q <= entries_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

endmodule
